// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
//   EX-stage front end for the ALU. It decodes op class, funct3 and funct7b5
//   into an ALU opcode and selects operand A and operand B. It can optionally
//   apply result forwarding. The selected operands are held in a two-entry
//   buffer (main + skid) that has valid/ready handshakes on both sides, so a
//   downstream stall never drops an op.
//
//   Optional feature: define ALU_OPERAND_FWD_EN to enable EX/MEM and MEM/WB
//   bypass of rs1/rs2. If it is undefined, the fwd_* ports are present but
//   ignored.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   flush                  synchronous kill of all buffered ops
//   in_valid / in_ready    upstream handshake (in_ready is registered)
//   in_op_sel              00 R-type, 01 I-type ALU, 10 address calc, 11 branch
//   in_funct3, in_funct7b5 instruction function fields
//   in_rs1, in_rs2         source register indices
//   in_rs1_data/rs2_data   register file read data
//   in_imm                 sign-extended immediate
//   in_rd                  destination register index
//   fwd_mem_*, fwd_wb_*    result bypass sources (MEM has priority over WB)
//   out_valid / out_ready  downstream handshake
//   ALU_ctr                ALU opcode (4'hF = illegal)
//   ALU_srcA, ALU_srcB     ALU operands
//   out_rs2_data           store data (the resolved rs2 value)
//   out_rd                 destination register index
//   out_illegal            high when ALU_ctr is the illegal code
// ---------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op_sel,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic [RADDR-1:0] in_rs1,
  input  logic [RADDR-1:0] in_rs2,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [RADDR-1:0] in_rd,
  input  logic             fwd_mem_we,
  input  logic [RADDR-1:0] fwd_mem_rd,
  input  logic [XLEN-1:0]  fwd_mem_data,
  input  logic             fwd_wb_we,
  input  logic [RADDR-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0]  fwd_wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       ALU_ctr,
  output logic [XLEN-1:0]  ALU_srcA,
  output logic [XLEN-1:0]  ALU_srcB,
  output logic [XLEN-1:0]  out_rs2_data,
  output logic [RADDR-1:0] out_rd,
  output logic             out_illegal
);

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLL = 4'h5;
  localparam logic [3:0] ALU_SRL = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;
  localparam logic [3:0] ALU_ILL = 4'hF;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_t;

  typedef struct packed {
    logic [3:0]       ctr;
    logic             illegal;
    logic [XLEN-1:0]  src_a;
    logic [XLEN-1:0]  src_b;
    logic [XLEN-1:0]  rs2_data;
    logic [RADDR-1:0] rd;
  } payload_t;

  state_t          state_r;
  logic            out_valid_r;
  logic            in_ready_r;
  payload_t        main_r;
  payload_t        skid_r;
  payload_t        in_pl_s;
  logic [3:0]      dec_ctr_s;
  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;

`ifdef ALU_OPERAND_FWD_EN
  // Bypass priority is MEM over WB over register file. x0 is never forwarded.
  function automatic logic [XLEN-1:0] resolve_operand(
    input logic [RADDR-1:0] rs,
    input logic [XLEN-1:0]  rf_data,
    input logic             mem_we,
    input logic [RADDR-1:0] mem_rd,
    input logic [XLEN-1:0]  mem_data,
    input logic             wb_we,
    input logic [RADDR-1:0] wb_rd,
    input logic [XLEN-1:0]  wb_data
  );
    logic [XLEN-1:0] val;
    if (mem_we && (mem_rd == rs) && (rs != '0)) begin
      val = mem_data;
    end else if (wb_we && (wb_rd == rs) && (rs != '0)) begin
      val = wb_data;
    end else begin
      val = rf_data;
    end
    return val;
  endfunction

  // Operand values are resolved only here, at capture time.
  always_comb begin
    rs1_val_s = resolve_operand(in_rs1, in_rs1_data, fwd_mem_we, fwd_mem_rd,
                                fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data);
    rs2_val_s = resolve_operand(in_rs2, in_rs2_data, fwd_mem_we, fwd_mem_rd,
                                fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data);
  end
`else
  logic unused_fwd_s;
  assign unused_fwd_s = ^{in_rs1, in_rs2, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                          fwd_wb_we, fwd_wb_rd, fwd_wb_data};

  // Without forwarding, operands come straight from the register file.
  always_comb begin
    rs1_val_s = in_rs1_data;
    rs2_val_s = in_rs2_data;
  end
`endif

  // Opcode decode. SRA and SLTU are not supported by the ALU and map to ILL.
  always_comb begin
    dec_ctr_s = ALU_ILL;
    case (in_op_sel)
      2'b00, 2'b01: begin
        case (in_funct3)
          3'b000: begin
            if ((in_op_sel == 2'b00) && in_funct7b5) begin
              dec_ctr_s = ALU_SUB;
            end else begin
              dec_ctr_s = ALU_ADD;
            end
          end
          3'b001: dec_ctr_s = ALU_SLL;
          3'b010: dec_ctr_s = ALU_SLT;
          3'b100: dec_ctr_s = ALU_XOR;
          3'b101: begin
            if (!in_funct7b5) begin
              dec_ctr_s = ALU_SRL;
            end else begin
              dec_ctr_s = ALU_ILL;
            end
          end
          3'b110: dec_ctr_s = ALU_OR;
          3'b111: dec_ctr_s = ALU_AND;
          default: dec_ctr_s = ALU_ILL;
        endcase
      end
      2'b10:   dec_ctr_s = ALU_ADD;
      2'b11:   dec_ctr_s = ALU_SUB;
      default: dec_ctr_s = ALU_ILL;
    endcase
  end

  // Assemble the payload of the incoming op. I-type and address calc use the immediate.
  always_comb begin
    in_pl_s          = '0;
    in_pl_s.ctr      = dec_ctr_s;
    in_pl_s.illegal  = (dec_ctr_s == ALU_ILL);
    in_pl_s.src_a    = rs1_val_s;
    in_pl_s.rs2_data = rs2_val_s;
    in_pl_s.rd       = in_rd;
    if ((in_op_sel == 2'b01) || (in_op_sel == 2'b10)) begin
      in_pl_s.src_b = in_imm;
    end else begin
      in_pl_s.src_b = rs2_val_s;
    end
  end

  // Occupancy FSM with the main and skid payload registers. Payload holds while invalid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      main_r      <= '0;
      skid_r      <= '0;
    end else if (flush) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_valid) begin
            main_r      <= in_pl_s;
            state_r     <= ST_ONE;
            out_valid_r <= 1'b1;
          end
        end
        ST_ONE: begin
          if (in_valid && !out_ready) begin
            // Main is stalled, so the new op parks in skid behind it.
            skid_r     <= in_pl_s;
            state_r    <= ST_TWO;
            in_ready_r <= 1'b0;
          end else if (in_valid && out_ready) begin
            main_r <= in_pl_s;
          end else if (out_ready) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        ST_TWO: begin
          if (out_ready) begin
            main_r     <= skid_r;
            state_r    <= ST_ONE;
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign ALU_ctr      = main_r.ctr;
  assign out_illegal  = main_r.illegal;
  assign ALU_srcA     = main_r.src_a;
  assign ALU_srcB     = main_r.src_b;
  assign out_rs2_data = main_r.rs2_data;
  assign out_rd       = main_r.rd;

endmodule
